regbank_wr_arb: RTL
===================

REGBANK_WR_ARB -- requirements
Module: regbank_wr_arb

Interface
REQ-001 Parameter WIDTH, default 8, data width of each bank register.
REQ-002 Parameter NREG, default 4, number of bank registers (power of 2, 2..16); AW = log2(NREG).
REQ-003 Parameter NREQ, default 4, number of write requesters (2..8).
REQ-004 Parameter LOCK_MAX, default 4, max consecutive grants to one locked owner (1..15).
REQ-005 clk  input  1  clock; all state updates on rising edge.
REQ-006 reset_n  input  1  reset, asynchronous, active-low.
REQ-007 req  input  NREQ  per-requester write request, level.
REQ-008 lock  input  NREQ  per-requester burst-lock qualifier, meaningful only with matching req bit.
REQ-009 wr_addr  input  NREQ*AW  flattened target register index, requester i at slice [i*AW +: AW].
REQ-010 wr_data  input  NREQ*WIDTH  flattened write data, requester i at slice [i*WIDTH +: WIDTH].
REQ-011 gnt  output  NREQ  one-hot or zero grant, combinational from req, lock and registered state.
REQ-012 reg_ce  output  NREG  one-hot or zero clock enable of the bank register written this cycle.
REQ-013 reg_q  output  NREG*WIDTH  flattened bank register contents, register k at [k*WIDTH +: WIDTH].
REQ-014 busy  output  1  registered; 1 while FSM in LOCKED.

Function
REQ-015 Bank SHALL be NREG clock-enabled registers; register k loads granted wr_data at rising edge when reg_ce[k]=1, else holds.
REQ-016 Write latency SHALL be one edge: data granted in cycle N visible on reg_q after edge ending cycle N.
REQ-017 At most one gnt bit and one reg_ce bit SHALL be high per cycle; reg_ce[k]=1 iff some gnt[i]=1 and wr_addr slice i = k.
REQ-018 No req bit high -> gnt=0, reg_ce=0, bank unchanged.
REQ-019 Handshake: requester holds req, addr, data stable until the cycle gnt[i]=1; that cycle completes the write; req still high next cycle is a new request.
REQ-020 FSM states IDLE and LOCKED; registers ptr (round-robin pointer, log2(NREQ) bits), owner, lock_cnt (4 bits).
REQ-021 IDLE: grant first requester with req set searching ptr, ptr+1, ... mod NREQ.
REQ-022 IDLE grant to i with lock[i]=0: ptr <= (i+1) mod NREQ, stay IDLE.
REQ-023 IDLE grant to i with lock[i]=1 and LOCK_MAX>1: owner <= i, lock_cnt <= 1, go LOCKED; ptr unchanged.
REQ-024 LOCKED: only owner is eligible; gnt[owner]=1 iff req[owner]=1; all other requesters wait regardless of ptr.
REQ-025 LOCKED grant: lock_cnt increments; if lock[owner]=0 or lock_cnt+1 = LOCK_MAX, go IDLE and ptr <= (owner+1) mod NREQ.
REQ-026 LOCKED with req[owner]=0: no grant that cycle, go IDLE, ptr <= (owner+1) mod NREQ.
REQ-027 Forced release at LOCK_MAX: owner SHALL not be granted on the next cycle if any other requester has req set (RR resumes past owner).
REQ-028 lock bits without req SHALL be ignored; lock changes on a non-granted requester SHALL have no effect.
REQ-029 Two requesters targeting same address SHALL be served in grant order, later write overwriting earlier.
REQ-030 X-free: gnt, reg_ce, busy SHALL be defined whenever req is defined.

Reset
REQ-031 reset_n=0 SHALL immediately clear all reg_q to 0, ptr to 0, owner to 0, lock_cnt to 0, busy to 0, FSM to IDLE.
REQ-032 Reset asserted mid-lock SHALL abort LOCKED; the write of a cycle in which reset_n=0 SHALL be discarded.
REQ-033 After reset release, first grant SHALL follow ptr=0 priority (requester 0 first).

Verification
REQ-034 Reset then req=4'b0001, addr0=2, data0=8'hA5 one cycle -> gnt=0001, reg_ce=0100, reg_q[2]=8'hA5 next cycle, others 0.
REQ-035 req=4'b1111 held, lock=0, 8 cycles -> gnt sequence 0001,0010,0100,1000,0001,0010,0100,1000.
REQ-036 req=4'b0011, lock=4'b0001, LOCK_MAX=4 -> gnt 0001 x4 with busy=1 during cycles 2-4, then 0010; busy=0 after release.
REQ-037 Owner 2 locked, req[2] drops in second locked cycle with req[3]=1 -> no grant that cycle, then gnt=1000.
REQ-038 Requesters 0 and 1 both target addr 3 with 8'h11 / 8'h22 -> reg_q[3]=8'h11 after first edge, 8'h22 after second.
REQ-039 reset_n pulsed low during LOCKED with pending write data 8'hFF -> reg_q all 0, busy=0, next grant to requester 0.

Source files
------------

// File: rtl/regbank_wr_arb.sv
// Write arbiter for a small register bank. Requesters are served round-robin, and a
// requester holding lock keeps the grant for up to LOCK_MAX consecutive writes.
module regbank_wr_arb #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned NREG     = 4,
  parameter int unsigned NREQ     = 4,
  parameter int unsigned LOCK_MAX = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ-1:0]         lock,
  input  logic [NREQ*$clog2(NREG)-1:0] wr_addr,
  input  logic [NREQ*WIDTH-1:0]   wr_data,
  output logic [NREQ-1:0]         gnt,
  output logic [NREG-1:0]         reg_ce,
  output logic [NREG*WIDTH-1:0]   reg_q,
  output logic                    busy
);

  localparam int unsigned AW = $clog2(NREG);
  localparam int unsigned PW = $clog2(NREQ);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] LOCKED = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [PW-1:0]    owner_q, owner_d;
  logic [3:0]       lock_cnt_q, lock_cnt_d;

  logic             gnt_any;
  logic [PW-1:0]    gnt_idx;
  logic [AW-1:0]    sel_addr;
  logic [WIDTH-1:0] sel_data;
  logic [WIDTH-1:0] bank_q [NREG];

  // NREQ need not be a power of two, so the wrap is explicit.
  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] i);
    if (32'(i) == NREQ - 1) begin
      return '0;
    end
    return i + PW'(1);
  endfunction

  // Winner selection: locked owner only, otherwise first request from ptr upward.
  always_comb begin
    int unsigned cand;
    cand    = 0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    if (state_q == LOCKED) begin
      gnt_any = req[owner_q];
      gnt_idx = owner_q;
    end else begin
      for (int unsigned off = 0; off < NREQ; off++) begin
        cand = (32'(ptr_q) + off) % NREQ;
        if (!gnt_any && req[cand]) begin
          gnt_any = 1'b1;
          gnt_idx = PW'(cand);
        end
      end
    end
  end

  always_comb begin
    sel_addr = wr_addr[32'(gnt_idx) * AW +: AW];
    sel_data = wr_data[32'(gnt_idx) * WIDTH +: WIDTH];
    gnt      = '0;
    reg_ce   = '0;
    if (gnt_any) begin
      gnt[gnt_idx]     = 1'b1;
      reg_ce[sel_addr] = 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    owner_d    = owner_q;
    lock_cnt_d = lock_cnt_q;
    case (state_q)
      IDLE: begin
        if (gnt_any) begin
          // With LOCK_MAX of 1 a lock can never extend past the first grant.
          if (lock[gnt_idx] && (LOCK_MAX > 1)) begin
            owner_d    = gnt_idx;
            lock_cnt_d = 4'd1;
            state_d    = LOCKED;
          end else begin
            ptr_d = wrap_inc(gnt_idx);
          end
        end
      end
      LOCKED: begin
        if (gnt_any) begin
          lock_cnt_d = lock_cnt_q + 4'd1;
          if (!lock[owner_q] || (32'(lock_cnt_q) + 1 == LOCK_MAX)) begin
            state_d = IDLE;
            ptr_d   = wrap_inc(owner_q);
          end
        end else begin
          state_d = IDLE;
          ptr_d   = wrap_inc(owner_q);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      owner_q    <= '0;
      lock_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      owner_q    <= owner_d;
      lock_cnt_q <= lock_cnt_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < NREG; k++) begin
        bank_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NREG; k++) begin
        if (reg_ce[k]) begin
          bank_q[k] <= sel_data;
        end
      end
    end
  end

  for (genvar k = 0; k < NREG; k++) begin : g_reg_q
    assign reg_q[k*WIDTH +: WIDTH] = bank_q[k];
  end

  assign busy = (state_q == LOCKED);

  a_gnt_onehot0 : assert property (@(posedge clk) disable iff (!reset_n) $onehot0(gnt));
  a_ce_onehot0  : assert property (@(posedge clk) disable iff (!reset_n) $onehot0(reg_ce));
  a_ce_iff_gnt  : assert property (@(posedge clk) disable iff (!reset_n)
                                   (|gnt) == (|reg_ce));

endmodule
